calc_input_ctrl: RTL and testbench

- Operand/opcode entry sequencer sitting directly upstream of the 4-bit calculator ALU.
- Synchronises and debounces the ENTER and CLEAR push-buttons.
- Steps a 4-state FSM that captures operand A, then operand B, then the opcode from the slide switches.
- Presents stable a/b/op registers plus a result_valid flag; the ALU is purely combinational off these registers.

---
 rtl/calc_input_ctrl.sv | 164 ++++++++++++++++
 tb/tb_calc_input_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : calc_input_ctrl
//  Desc     : Operand/opcode entry sequencer for the 4-bit calculator ALU.
//             Synchronises and debounces ENTER/CLEAR, then captures operand A,
//             operand B and the opcode from the slide switches.
//  Revision : 1.0  initial release
// ============================================================================
module calc_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] sw,
   input  logic       btn_enter_raw,
   input  logic       btn_clear_raw,
   output logic [3:0] a,
   output logic [3:0] b,
   output logic [2:0] op,
   output logic [1:0] stage,
   output logic       result_valid
);

   localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   typedef enum logic [1:0] {
      ST_ENTER_A  = 2'd0,
      ST_ENTER_B  = 2'd1,
      ST_ENTER_OP = 2'd2,
      ST_SHOW     = 2'd3
   } state_t;

   // Index 0 = ENTER, index 1 = CLEAR; both channels are identical.
   logic [1:0] w_raw;
   logic [1:0] w_btn;
   logic [1:0] w_pulse;

   assign w_raw = {btn_clear_raw, btn_enter_raw};
   assign w_btn = BTN_ACTIVE_LOW ? ~w_raw : w_raw;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         logic               r_s1;
         logic               r_s2;
         logic               r_db;
         logic               r_pulse;
         logic [c_CNT_W-1:0] r_cnt;

         // Two-flop synchroniser, debounce counter and one-shot press pulse.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_s1    <= 1'b0;
               r_s2    <= 1'b0;
               r_db    <= 1'b0;
               r_pulse <= 1'b0;
               r_cnt   <= '0;
            end else begin
               r_s1    <= w_btn[gi];
               r_s2    <= r_s1;
               r_pulse <= 1'b0;
               if (r_s2 == r_db) begin
                  r_cnt <= '0;
               end else if (r_cnt == c_CNT_LAST) begin
                  // Threshold reached: adopt the new level; pulse on press only.
                  r_db    <= r_s2;
                  r_cnt   <= '0;
                  r_pulse <= r_s2;
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
         end

         assign w_pulse[gi] = r_pulse;
      end
   endgenerate

   logic       w_enter_pulse;
   logic       w_clear_pulse;

   assign w_enter_pulse = w_pulse[0];
   assign w_clear_pulse = w_pulse[1];

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_a;
   logic [3:0] r_b;
   logic [2:0] r_op;
   logic       r_valid;
   logic [3:0] w_a_nxt;
   logic [3:0] w_b_nxt;
   logic [2:0] w_op_nxt;
   logic       w_valid_nxt;

   // Entry sequencer: CLEAR has priority over ENTER; nothing changes without a pulse.
   always_comb begin
      w_state_nxt = r_state;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_op_nxt    = r_op;
      w_valid_nxt = r_valid;
      if (w_clear_pulse) begin
         w_state_nxt = ST_ENTER_A;
         w_a_nxt     = 4'd0;
         w_b_nxt     = 4'd0;
         w_op_nxt    = 3'd0;
         w_valid_nxt = 1'b0;
      end else if (w_enter_pulse) begin
         case (r_state)
            ST_ENTER_A: begin
               w_a_nxt     = sw;
               w_state_nxt = ST_ENTER_B;
            end
            ST_ENTER_B: begin
               w_b_nxt     = sw;
               w_state_nxt = ST_ENTER_OP;
            end
            ST_ENTER_OP: begin
               // Codes 6/7 are kept as-is; the ALU treats them as no-ops.
               w_op_nxt    = sw[2:0];
               w_state_nxt = ST_SHOW;
               w_valid_nxt = 1'b1;
            end
            ST_SHOW: begin
               // Operands are retained so the ALU inputs stay glitch-free.
               w_state_nxt = ST_ENTER_A;
               w_valid_nxt = 1'b0;
            end
            default: begin
               w_state_nxt = ST_ENTER_A;
            end
         endcase
      end
   end

   // State and captured-operand registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_ENTER_A;
         r_a     <= 4'd0;
         r_b     <= 4'd0;
         r_op    <= 3'd0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_op    <= w_op_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   assign a            = r_a;
   assign b            = r_b;
   assign op           = r_op;
   assign stage        = r_state;
   assign result_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_calc_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calc_input_ctrl
//  Desc     : Self-checking bench for calc_input_ctrl (DEBOUNCE_CYCLES=4,
//             active-low buttons). Expected output vectors {a,b,op,stage,valid}
//             come from a small behavioural model and are queued per press.
//  Revision : 1.0  initial release
// ============================================================================
module tb_calc_input_ctrl;

   logic       clk;
   logic       rst_n;
   logic [3:0] sw;
   logic       btn_enter_raw;
   logic       btn_clear_raw;
   logic [3:0] a;
   logic [3:0] b;
   logic [2:0] op;
   logic [1:0] stage;
   logic       result_valid;

   calc_input_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .BTN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sw            (sw),
      .btn_enter_raw (btn_enter_raw),
      .btn_clear_raw (btn_clear_raw),
      .a             (a),
      .b             (b),
      .op            (op),
      .stage         (stage),
      .result_valid  (result_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_pass;
   int          n_total;
   logic [13:0] exp_q[$];
   logic [13:0] m_prev;
   logic [13:0] got;
   logic [13:0] expv;

   // Reference model state.
   logic [3:0]  m_a;
   logic [3:0]  m_b;
   logic [2:0]  m_op;
   logic [1:0]  m_stage;
   logic        m_valid;

   function automatic logic [13:0] obs();
      return {a, b, op, stage, result_valid};
   endfunction

   function automatic logic [13:0] mvec();
      return {m_a, m_b, m_op, m_stage, m_valid};
   endfunction

   task automatic model_clear();
      m_a = 4'd0; m_b = 4'd0; m_op = 3'd0; m_stage = 2'd0; m_valid = 1'b0;
   endtask

   task automatic model_enter(input logic [3:0] swv);
      case (m_stage)
         2'd0: begin m_a = swv;       m_stage = 2'd1; end
         2'd1: begin m_b = swv;       m_stage = 2'd2; end
         2'd2: begin m_op = swv[2:0]; m_stage = 2'd3; m_valid = 1'b1; end
         default: begin               m_stage = 2'd0; m_valid = 1'b0; end
      endcase
   endtask

   // Press the selected buttons (held) and stop just after edge 6: one edge
   // before the sequencer is expected to act on the pulse.
   task automatic drive_press(input logic en, input logic cl, input logic [3:0] swv);
      m_prev = mvec();
      sw     = swv;
      if (cl)      model_clear();
      else if (en) model_enter(swv);
      exp_q.push_back(mvec());
      btn_enter_raw = ~en;
      btn_clear_raw = ~cl;
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic drive_release();
      btn_enter_raw = 1'b1;
      btn_clear_raw = 1'b1;
      repeat (10) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; btn_enter_raw = 1'b1; btn_clear_raw = 1'b1; sw = 4'd0;
      @(posedge clk); #1;
      #3;                                  // mid-cycle, away from any edge
      rst_n = 1'b0; btn_enter_raw = 1'b0; sw = 4'd7;
      #1;
      model_clear();
      got = obs(); n_total++;
      if (got !== mvec()) $display("FAIL reset_async got=%h exp=%h", got, mvec());
      else n_pass++;
      repeat (2) @(posedge clk); #1;
      m_prev = mvec();
      model_enter(4'd7);
      exp_q.push_back(mvec());
      rst_n = 1'b1;                        // ENTER already held during reset
      repeat (6) @(posedge clk); #1;
      got = obs(); n_total++;
      if (got !== m_prev) $display("FAIL reset_early got=%h exp=%h", got, m_prev);
      else n_pass++;
      @(posedge clk); #1;
      expv = exp_q.pop_front();
      got = obs(); n_total++;
      if (got !== expv) $display("FAIL reset_capture got=%h exp=%h", got, expv);
      else n_pass++;
      drive_release();
      rst_n = 1'b0; #2; rst_n = 1'b1;
      model_clear();
      @(posedge clk); #1;
   endtask

   task automatic test_full_entry();
      logic [3:0] vals [4];
      vals[0] = 4'd3; vals[1] = 4'd5; vals[2] = 4'd0; vals[3] = 4'hF;
      for (int i = 0; i < 4; i++) begin
         drive_press(1'b1, 1'b0, vals[i]);
         got = obs(); n_total++;
         if (got !== m_prev) $display("FAIL entry%0d_early got=%h exp=%h", i, got, m_prev);
         else n_pass++;
         @(posedge clk); #1;
         expv = exp_q.pop_front();
         got = obs(); n_total++;
         if (got !== expv) $display("FAIL entry%0d got=%h exp=%h", i, got, expv);
         else n_pass++;
         drive_release();
      end
   endtask

   task automatic test_bounce();
      logic pat [8];
      for (int i = 0; i < 8; i++) pat[i] = (i / 2) % 2 == 1;  // 0,0,1,1,0,0,1,1
      sw = 4'd4;
      for (int i = 0; i < 8; i++) begin
         btn_enter_raw = pat[i];
         @(posedge clk); #1;
      end
      drive_press(1'b1, 1'b0, 4'd4);       // final stable low
      got = obs(); n_total++;
      if (got !== m_prev) $display("FAIL bounce_early got=%h exp=%h", got, m_prev);
      else n_pass++;
      @(posedge clk); #1;
      expv = exp_q.pop_front();
      got = obs(); n_total++;
      if (got !== expv) $display("FAIL bounce_capture got=%h exp=%h", got, expv);
      else n_pass++;
      // Held for 50 cycles with switches moving: no second capture.
      for (int i = 0; i < 50; i++) begin
         sw = 4'(i);
         @(posedge clk); #1;
      end
      got = obs(); n_total++;
      if (got !== mvec()) $display("FAIL bounce_hold got=%h exp=%h", got, mvec());
      else n_pass++;
      drive_release();
   endtask

   task automatic test_glitch();
      sw = 4'd9;
      btn_enter_raw = 1'b0;
      repeat (3) @(posedge clk); #1;
      btn_enter_raw = 1'b1;
      repeat (15) @(posedge clk); #1;
      got = obs(); n_total++;
      if (got !== mvec()) $display("FAIL glitch got=%h exp=%h", got, mvec());
      else n_pass++;
   endtask

   task automatic test_clear();
      drive_press(1'b1, 1'b0, 4'd9); @(posedge clk); #1; drive_release();
      drive_press(1'b1, 1'b0, 4'd6); @(posedge clk); #1; drive_release();
      void'(exp_q.pop_front());
      expv = exp_q.pop_front();
      got = obs(); n_total++;
      if (got !== expv) $display("FAIL clear_setup got=%h exp=%h", got, expv);
      else n_pass++;
      drive_press(1'b0, 1'b1, 4'd6);
      @(posedge clk); #1;
      expv = exp_q.pop_front();
      got = obs(); n_total++;
      if (got !== expv) $display("FAIL clear got=%h exp=%h", got, expv);
      else n_pass++;
      drive_release();
      drive_press(1'b1, 1'b1, 4'd8);       // both aligned: CLEAR must win
      @(posedge clk); #1;
      expv = exp_q.pop_front();
      got = obs(); n_total++;
      if (got !== expv) $display("FAIL clear_vs_enter got=%h exp=%h", got, expv);
      else n_pass++;
      drive_release();
      got = obs(); n_total++;
      if (got !== mvec()) $display("FAIL clear_after got=%h exp=%h", got, mvec());
      else n_pass++;
   endtask

   task automatic test_invalid_op();
      drive_press(1'b1, 1'b0, 4'd1);  @(posedge clk); #1; drive_release();
      drive_press(1'b1, 1'b0, 4'd2);  @(posedge clk); #1; drive_release();
      drive_press(1'b1, 1'b0, 4'hF);  @(posedge clk); #1;
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      expv = exp_q.pop_front();
      got = obs(); n_total++;
      if (got !== expv) $display("FAIL invalid_op got=%h exp=%h", got, expv);
      else n_pass++;
      drive_release();
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      rst_n = 1'b1; sw = 4'd0; btn_enter_raw = 1'b1; btn_clear_raw = 1'b1;
      model_clear();
      test_reset();
      test_full_entry();
      test_bounce();
      test_glitch();
      test_clear();
      test_invalid_op();
      n_total++;
      if (exp_q.size() != 0) $display("FAIL queue_drain left=%0d exp=0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
